lap_recorder: RTL and testbench
===============================

# lap_recorder

Lap/split capture stage between the stopwatch counter and the seven-segment display path. Snapshots the live BCD time (min10/min1/sec10/sec1) on each lap request into a small circular buffer. Drives either the live time or a recalled lap onto the digit outputs consumed by the per-digit seven_seg_display decoders.

## Interface
- DEPTH, 4, number of lap entries; power of two, 2..16
- PTR_W, $clog2(DEPTH), buffer pointer width (derived)
- s_clk  in  1  block clock
- rst_deb  in  1  reset rst_deb, asynchronous, active-high; clock s_clk
- live_min10, live_min1, live_sec10, live_sec1  in  4 each  live BCD digits from the stopwatch counter
- lap_pulse  in  1  single-cycle capture request, synchronous to s_clk
- recall_pulse  in  1  single-cycle enter/step-recall request
- clr_pulse  in  1  single-cycle buffer clear request
- disp_min10, disp_min1, disp_sec10, disp_sec1  out  4 each  registered digits to display decoders
- lap_num  out  PTR_W+1  1-based index of the displayed lap; 0 when showing live time
- lap_count  out  PTR_W+1  valid entries held, 0..DEPTH
- full  out  1  lap_count == DEPTH
- recall_active  out  1  high in RECALL state

## Operation
- States: LIVE, RECALL. Reset -> LIVE.
- Buffer: ring of DEPTH 16-bit entries; wr_ptr = next write slot; oldest = wr_ptr - lap_count (mod DEPTH).
- LIVE, lap_pulse: write live digits at wr_ptr; wr_ptr+1 (wraps at DEPTH); lap_count+1, saturating at DEPTH. When full, the write overwrites the oldest entry and lap_count stays DEPTH.
- LIVE, recall_pulse with lap_count>0: go RECALL, rd_idx=0 (oldest). With lap_count==0: ignored, stay LIVE.
- LIVE, clr_pulse: lap_count=0, wr_ptr=0; entry contents need not be zeroed.
- RECALL, recall_pulse: if rd_idx == lap_count-1, go LIVE; else rd_idx+1.
- RECALL: lap_pulse and clr_pulse are ignored (no write, no clear). The stopwatch keeps running underneath.
- Simultaneous pulses in LIVE, in priority order:
  - clr_pulse beats lap_pulse; the result is an empty buffer.
  - lap_pulse + recall_pulse: capture is committed first. RECALL is entered with the post-capture lap_count and rd_idx=0.
  - clr_pulse + recall_pulse: clear wins; stay LIVE.
- Display select: LIVE -> disp = live digits, lap_num=0. RECALL -> disp = buffer[oldest+rd_idx], lap_num = rd_idx+1.
- Digits pass through unmodified; no BCD validation.

## Timing
- Reset (async assert, registered release): state LIVE, wr_ptr=0, rd_idx=0, lap_count=0, full=0, recall_active=0, all disp digits 0, lap_num=0.
- All outputs registered.
- Live digits appear on disp one s_clk cycle after they appear on live_* inputs.
- lap_pulse at edge t: the entry holds the live_* values sampled at edge t. lap_count/full update at edge t.
- recall_pulse at edge t: recall_active, lap_num and the recalled digits are valid after edge t (same edge).
- rst_deb asserted mid-RECALL: immediate return to LIVE with the empty-buffer values above.
- Pulses are assumed one cycle wide. A pulse held high is treated as one event per cycle.

## Structure
- Shared package stopwatch_pkg:
  - bcd_time_t packed struct {min10, min1, sec10, sec1}, 4 bits each, 16 bits total.
  - lap_state_t enum {LIVE, RECALL}.
  - LAP_DEPTH_DEFAULT = 4.
- One sub-module, lap_ring_buf: DEPTH x bcd_time_t register file with a write port (we, waddr, wdata) and an asynchronous read port (raddr). Pointer, count and FSM logic stay in lap_recorder.

## Test plan
- Reset, then live=03:27 -> next cycle disp=03:27, lap_num=0, lap_count=0, full=0.
- Laps at 00:05, 00:12, 00:31, then recall x4 -> disp 00:05 (lap_num 1), 00:12 (2), 00:31 (3), then back to LIVE with recall_active=0.
- DEPTH=4, five laps at 01:00..05:00, then recall -> lap_count=4, full=1, first recalled entry 02:00.
- Recall with empty buffer -> stays LIVE. lap_pulse and recall_pulse in the same cycle at 00:09 with empty buffer -> RECALL, disp=00:09, lap_num=1, lap_count=1.
- In RECALL, issue lap_pulse and clr_pulse -> lap_count unchanged, no entry modified. In LIVE, clr_pulse+lap_pulse together -> lap_count=0.
- rst_deb asserted while showing lap 2 of 3 -> same cycle recall_active=0, lap_count=0, disp=00:00.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Types and constants shared by the stopwatch display path.
package stopwatch_pkg;

  typedef struct packed {
    logic [3:0] min10;
    logic [3:0] min1;
    logic [3:0] sec10;
    logic [3:0] sec1;
  } bcd_time_t;

  typedef enum logic {
    LIVE   = 1'b0,
    RECALL = 1'b1
  } lap_state_t;

  localparam int LAP_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/lap_ring_buf.sv
// Lap storage: DEPTH x bcd_time_t register file, one write port, asynchronous read.
module lap_ring_buf
  import stopwatch_pkg::*;
#(
  parameter int DEPTH = LAP_DEPTH_DEFAULT,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             s_clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  bcd_time_t        wdata,
  input  logic [PTR_W-1:0] raddr,
  output bcd_time_t        rdata
);

  bcd_time_t r_mem [DEPTH];

  // Contents are never reset; lap_count alone decides which slots are valid.
  always_ff @(posedge s_clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/lap_recorder.sv
// Lap/split capture: snapshots live BCD time into a ring and shows live time or a recalled lap.
module lap_recorder
  import stopwatch_pkg::*;
#(
  parameter int DEPTH = LAP_DEPTH_DEFAULT,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             s_clk,
  input  logic             rst_deb,
  input  logic [3:0]       live_min10,
  input  logic [3:0]       live_min1,
  input  logic [3:0]       live_sec10,
  input  logic [3:0]       live_sec1,
  input  logic             lap_pulse,
  input  logic             recall_pulse,
  input  logic             clr_pulse,
  output logic [3:0]       disp_min10,
  output logic [3:0]       disp_min1,
  output logic [3:0]       disp_sec10,
  output logic [3:0]       disp_sec1,
  output logic [PTR_W:0]   lap_num,
  output logic [PTR_W:0]   lap_count,
  output logic             full,
  output logic             recall_active
);

  localparam logic [PTR_W:0] L_DEPTH = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] L_ONE   = (PTR_W + 1)'(1);

  lap_state_t       r_state, w_state_next;
  logic [PTR_W-1:0] r_wr_ptr, w_wr_ptr_next;
  logic [PTR_W-1:0] r_rd_idx, w_rd_idx_next;
  logic [PTR_W:0]   r_count, w_count_next;
  logic [PTR_W:0]   r_lap_num, w_lap_num_next;
  logic             r_full;
  logic             w_we;
  logic [PTR_W-1:0] w_raddr;
  bcd_time_t        w_live, w_ring_rdata, w_rdata, w_disp_next, r_disp;

  assign w_live = bcd_time_t'({live_min10, live_min1, live_sec10, live_sec1});

  lap_ring_buf #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ring (
    .s_clk (s_clk),
    .we    (w_we),
    .waddr (r_wr_ptr),
    .wdata (w_live),
    .raddr (w_raddr),
    .rdata (w_ring_rdata)
  );

  always_comb begin
    w_state_next  = r_state;
    w_wr_ptr_next = r_wr_ptr;
    w_rd_idx_next = r_rd_idx;
    w_count_next  = r_count;
    w_we          = 1'b0;
    unique case (r_state)
      LIVE: begin
        if (clr_pulse) begin
          w_wr_ptr_next = '0;
          w_count_next  = '0;
        end else begin
          if (lap_pulse) begin
            w_we          = 1'b1;
            w_wr_ptr_next = r_wr_ptr + 1'b1;
            if (r_count != L_DEPTH) begin
              w_count_next = r_count + L_ONE;
            end
          end
          // Recall sees the post-capture count, so lap+recall on an empty ring still enters.
          if (recall_pulse && (w_count_next != '0)) begin
            w_state_next  = RECALL;
            w_rd_idx_next = '0;
          end
        end
      end
      RECALL: begin
        if (recall_pulse) begin
          if ({1'b0, r_rd_idx} == (r_count - L_ONE)) begin
            w_state_next  = LIVE;
            w_rd_idx_next = '0;
          end else begin
            w_rd_idx_next = r_rd_idx + 1'b1;
          end
        end
      end
      default: w_state_next = LIVE;
    endcase
  end

  // Read address uses next-cycle pointers so the recalled entry is shown on the same edge;
  // the bypass covers the slot being written on that same edge.
  always_comb begin
    w_raddr        = w_wr_ptr_next - w_count_next[PTR_W-1:0] + w_rd_idx_next;
    w_rdata        = (w_we && (w_raddr == r_wr_ptr)) ? w_live : w_ring_rdata;
    w_disp_next    = w_live;
    w_lap_num_next = '0;
    if (w_state_next == RECALL) begin
      w_disp_next    = w_rdata;
      w_lap_num_next = {1'b0, w_rd_idx_next} + L_ONE;
    end
  end

  always_ff @(posedge s_clk or posedge rst_deb) begin
    if (rst_deb) begin
      r_state   <= LIVE;
      r_wr_ptr  <= '0;
      r_rd_idx  <= '0;
      r_count   <= '0;
      r_full    <= 1'b0;
      r_lap_num <= '0;
      r_disp    <= '0;
    end else begin
      r_state   <= w_state_next;
      r_wr_ptr  <= w_wr_ptr_next;
      r_rd_idx  <= w_rd_idx_next;
      r_count   <= w_count_next;
      r_full    <= (w_count_next == L_DEPTH);
      r_lap_num <= w_lap_num_next;
      r_disp    <= w_disp_next;
    end
  end

  assign disp_min10    = r_disp.min10;
  assign disp_min1     = r_disp.min1;
  assign disp_sec10    = r_disp.sec10;
  assign disp_sec1     = r_disp.sec1;
  assign lap_num       = r_lap_num;
  assign lap_count     = r_count;
  assign full          = r_full;
  assign recall_active = (r_state == RECALL);

endmodule

// File: tb/tb_lap_recorder.sv
// Scoreboard bench for lap_recorder: stimulus queues expectations, a monitor compares them.
module tb_lap_recorder;

  logic       s_clk = 1'b0;
  logic       rst_deb = 1'b1;
  logic [3:0] live_min10 = '0, live_min1 = '0, live_sec10 = '0, live_sec1 = '0;
  logic       lap_pulse = 1'b0, recall_pulse = 1'b0, clr_pulse = 1'b0;
  logic [3:0] disp_min10, disp_min1, disp_sec10, disp_sec1;
  logic [2:0] lap_num, lap_count;
  logic       full, recall_active;

  typedef struct {
    string       name;
    logic [15:0] disp;
    int          num;
    int          cnt;
    bit          full;
    bit          rec;
  } exp_t;

  exp_t exp_q[$];
  event sample_ev;
  int   total = 0;
  int   bad   = 0;

  always #5 s_clk = ~s_clk;

  lap_recorder #(.DEPTH(4)) dut (
    .s_clk         (s_clk),
    .rst_deb       (rst_deb),
    .live_min10    (live_min10),
    .live_min1     (live_min1),
    .live_sec10    (live_sec10),
    .live_sec1     (live_sec1),
    .lap_pulse     (lap_pulse),
    .recall_pulse  (recall_pulse),
    .clr_pulse     (clr_pulse),
    .disp_min10    (disp_min10),
    .disp_min1     (disp_min1),
    .disp_sec10    (disp_sec10),
    .disp_sec1     (disp_sec1),
    .lap_num       (lap_num),
    .lap_count     (lap_count),
    .full          (full),
    .recall_active (recall_active)
  );

  task automatic expect_now(input string nm, input logic [15:0] ed, input int en, input int ec,
                            input bit ef, input bit er);
    exp_t e;
    e.name = nm; e.disp = ed; e.num = en; e.cnt = ec; e.full = ef; e.rec = er;
    exp_q.push_back(e);
    -> sample_ev;
  endtask

  // One clock of stimulus: drive at negedge, queue the expectation after the edge.
  task automatic cyc(input logic [15:0] lv, input bit lp, input bit rc, input bit cl,
                     input string nm, input logic [15:0] ed, input int en, input int ec,
                     input bit ef, input bit er);
    @(negedge s_clk);
    {live_min10, live_min1, live_sec10, live_sec1} = lv;
    lap_pulse    = lp;
    recall_pulse = rc;
    clr_pulse    = cl;
    @(posedge s_clk);
    expect_now(nm, ed, en, ec, ef, er);
  endtask

  initial begin : monitor
    exp_t        e;
    logic [15:0] got;
    forever begin
      @(sample_ev);
      #1;
      while (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {disp_min10, disp_min1, disp_sec10, disp_sec1};
        total++;
        if (got !== e.disp || int'(lap_num) != e.num || int'(lap_count) != e.cnt ||
            full !== e.full || recall_active !== e.rec) begin
          bad++;
          $display("FAIL %s: got disp=%h num=%0d cnt=%0d full=%0b rec=%0b, want disp=%h num=%0d cnt=%0d full=%0b rec=%0b",
                   e.name, got, lap_num, lap_count, full, recall_active,
                   e.disp, e.num, e.cnt, e.full, e.rec);
        end else begin
          $display("ok   %s: disp=%h num=%0d cnt=%0d full=%0b rec=%0b",
                   e.name, got, lap_num, lap_count, full, recall_active);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    #2;
    expect_now("reset_state", 16'h0000, 0, 0, 1'b0, 1'b0);
    @(negedge s_clk);
    rst_deb = 1'b0;

    cyc(16'h0327, 0, 0, 0, "live_passthru", 16'h0327, 0, 0, 0, 0);
    cyc(16'h0327, 0, 1, 0, "recall_empty",  16'h0327, 0, 0, 0, 0);
    cyc(16'h0005, 1, 0, 0, "lap_0005",      16'h0005, 0, 1, 0, 0);
    cyc(16'h0012, 1, 0, 0, "lap_0012",      16'h0012, 0, 2, 0, 0);
    cyc(16'h0031, 1, 0, 0, "lap_0031",      16'h0031, 0, 3, 0, 0);
    cyc(16'h0040, 0, 1, 0, "recall_1",      16'h0005, 1, 3, 0, 1);
    cyc(16'h0041, 0, 1, 0, "recall_2",      16'h0012, 2, 3, 0, 1);
    cyc(16'h0042, 0, 1, 0, "recall_3",      16'h0031, 3, 3, 0, 1);
    cyc(16'h0043, 0, 1, 0, "recall_exit",   16'h0043, 0, 3, 0, 0);
    cyc(16'h0050, 1, 0, 1, "clr_beats_lap", 16'h0050, 0, 0, 0, 0);

    cyc(16'h0100, 1, 0, 0, "fill_1",        16'h0100, 0, 1, 0, 0);
    cyc(16'h0200, 1, 0, 0, "fill_2",        16'h0200, 0, 2, 0, 0);
    cyc(16'h0300, 1, 0, 0, "fill_3",        16'h0300, 0, 3, 0, 0);
    cyc(16'h0400, 1, 0, 0, "fill_4_full",   16'h0400, 0, 4, 1, 0);
    cyc(16'h0500, 1, 0, 0, "overwrite",     16'h0500, 0, 4, 1, 0);
    cyc(16'h0600, 0, 1, 0, "oldest_after_wrap", 16'h0200, 1, 4, 1, 1);
    cyc(16'h0601, 1, 0, 1, "recall_ignores_lap_clr", 16'h0200, 1, 4, 1, 1);
    cyc(16'h0602, 0, 1, 0, "wrap_recall_2", 16'h0300, 2, 4, 1, 1);
    cyc(16'h0603, 0, 1, 0, "wrap_recall_3", 16'h0400, 3, 4, 1, 1);
    cyc(16'h0604, 0, 1, 0, "wrap_recall_4", 16'h0500, 4, 4, 1, 1);
    cyc(16'h0605, 0, 1, 0, "wrap_exit",     16'h0605, 0, 4, 1, 0);
    cyc(16'h0606, 0, 0, 1, "clr_full",      16'h0606, 0, 0, 0, 0);

    cyc(16'h0009, 1, 1, 0, "lap_and_recall_empty", 16'h0009, 1, 1, 0, 1);
    cyc(16'h0010, 0, 1, 0, "single_exit",   16'h0010, 0, 1, 0, 0);
    cyc(16'h0020, 1, 0, 0, "lap_0020",      16'h0020, 0, 2, 0, 0);
    cyc(16'h0030, 1, 0, 0, "lap_0030",      16'h0030, 0, 3, 0, 0);
    cyc(16'h0031, 0, 1, 0, "pre_rst_r1",    16'h0009, 1, 3, 0, 1);
    cyc(16'h0032, 0, 1, 0, "pre_rst_r2",    16'h0020, 2, 3, 0, 1);

    @(negedge s_clk);
    recall_pulse = 1'b0;
    rst_deb      = 1'b1;
    expect_now("async_rst_in_recall", 16'h0000, 0, 0, 0, 0);
    @(negedge s_clk);
    rst_deb = 1'b0;

    cyc(16'h0777, 0, 0, 0, "live_after_rst", 16'h0777, 0, 0, 0, 0);
    cyc(16'h0778, 0, 1, 0, "recall_after_rst", 16'h0778, 0, 0, 0, 0);
    cyc(16'h0111, 1, 0, 0, "lap_0111",      16'h0111, 0, 1, 0, 0);
    cyc(16'h0112, 0, 1, 1, "clr_beats_recall", 16'h0112, 0, 0, 0, 0);
    cyc(16'h0113, 0, 0, 0, "idle_end",      16'h0113, 0, 0, 0, 0);

    repeat (3) @(negedge s_clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
